sda_kernel_param_arbiter: RTL and testbench

- Shares the single kernel-side parameter read channel of the control parameter RAM between NumPorts independent kernel requesters.
- Uses round-robin arbitration and issues one parameter address per granted request.
- Tracks the requester index of every issued read in a tag FIFO, so returned parameter data is routed back to the correct requester in issue order.
- Sits between the kernel's parallel parameter-fetch stages and the parameter RAM block.

---
 rtl/sda_kernel_param_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sda_kernel_param_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_kernel_param_arbiter.sv
// sda_kernel_param_arbiter
//
// Purpose:
//   Shares the kernel-side parameter read channel of the control parameter
//   RAM between NumPorts independent requesters. A round-robin arbiter picks
//   one requester per cycle and loads its byte address into a single output
//   slot that faces the RAM. The index of every issued read is pushed into a
//   tag FIFO. Returned data is steered combinationally to the requester at
//   the FIFO head, so data always comes back in issue order.
//
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   i_reqAddrValid     per-requester address valid            [NumPorts]
//   i_reqAddr          per-requester address, 32 bits/port    [32*NumPorts]
//   o_reqAddrStop      per-requester address backpressure     [NumPorts]
//   o_reqDataValid     per-requester returned-data valid      [NumPorts]
//   o_reqData          per-requester returned data            [32*NumPorts]
//   i_reqDataStop      per-requester data backpressure        [NumPorts]
//   o_paramAddrValid   address valid towards the parameter RAM
//   o_paramAddr        address towards the parameter RAM      [32]
//   i_paramAddrStop    parameter RAM address backpressure
//   i_paramDataValid   returned data valid from the RAM
//   i_paramData        returned data from the RAM             [32]
//   o_paramDataStop    returned data backpressure
//   o_outstanding      reads issued but not yet returned      [TagPtrWidth+1]

module sda_kernel_param_arbiter #(
  parameter int NumPorts    = 4,
  parameter int PortIdWidth = 2,
  parameter int TagDepth    = 8,
  parameter int TagPtrWidth = 3
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [NumPorts-1:0]      i_reqAddrValid,
  input  logic [32*NumPorts-1:0]   i_reqAddr,
  output logic [NumPorts-1:0]      o_reqAddrStop,
  output logic [NumPorts-1:0]      o_reqDataValid,
  output logic [32*NumPorts-1:0]   o_reqData,
  input  logic [NumPorts-1:0]      i_reqDataStop,
  output logic                     o_paramAddrValid,
  output logic [31:0]              o_paramAddr,
  input  logic                     i_paramAddrStop,
  input  logic                     i_paramDataValid,
  input  logic [31:0]              i_paramData,
  output logic                     o_paramDataStop,
  output logic [TagPtrWidth:0]     o_outstanding
);

  localparam int CountWidth = TagPtrWidth + 1;
  localparam logic [TagPtrWidth:0]   CountFull = CountWidth'(TagDepth);
  localparam logic [TagPtrWidth:0]   CountOne  = 1;
  localparam logic [TagPtrWidth-1:0] PtrOne    = 1;

  // (base + step) mod NumPorts, used both for the scan order and for the
  // pointer update after a grant.
  function automatic logic [PortIdWidth-1:0] nextPort(
    input logic [PortIdWidth-1:0] base,
    input int                     step
  );
    int s;
    s = (int'(base) + step) % NumPorts;
    return PortIdWidth'(s);
  endfunction

  // Address slot
  logic                     r_slotValid;
  logic [31:0]              r_slotAddr;

  // Round-robin pointer: the first port examined in the next scan
  logic [PortIdWidth-1:0]   r_rrPtr;

  // Tag FIFO
  logic [PortIdWidth-1:0]   r_tagMem [TagDepth];
  logic [TagPtrWidth-1:0]   r_wrPtr;
  logic [TagPtrWidth-1:0]   r_rdPtr;
  logic [TagPtrWidth:0]     r_count;

  logic                     w_empty;
  logic                     w_full;
  logic [PortIdWidth-1:0]   w_head;
  logic                     w_headStop;
  logic                     w_dataStop;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_slotAccept;
  logic                     w_slotConsumed;
  logic                     w_canGrant;
  logic [PortIdWidth-1:0]   w_cand;
  logic [NumPorts-1:0]      w_grantVec;
  logic [PortIdWidth-1:0]   w_grantId;
  logic [31:0]              w_grantAddr;

  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == CountFull);
  assign w_head         = r_tagMem[r_rdPtr];
  assign w_slotConsumed = r_slotValid & ~i_paramAddrStop;
  assign w_slotAccept   = ~r_slotValid | ~i_paramAddrStop;

  // Return path. Data is steered to the requester at the FIFO head only;
  // with an empty FIFO nothing is routed and the RAM is held off, so stray
  // data can never be accepted.
  always_comb begin
    w_headStop     = 1'b0;
    o_reqDataValid = '0;
    o_reqData      = '0;
    for (int j = 0; j < NumPorts; j++) begin
      if (!w_empty && (w_head == PortIdWidth'(j))) begin
        w_headStop           = i_reqDataStop[j];
        o_reqDataValid[j]    = i_paramDataValid;
        o_reqData[32*j +: 32] = i_paramData;
      end
    end
  end

  assign w_dataStop      = w_empty | w_headStop;
  assign o_paramDataStop = w_dataStop;
  assign w_pop           = i_paramDataValid & ~w_dataStop;

  // Round-robin selection. Offsets are walked from the farthest to the
  // nearest so the last hit is the first valid port at or after r_rrPtr.
  // A full FIFO may still grant when it is popping in the same cycle.
  always_comb begin
    w_grantVec = '0;
    w_grantId  = '0;
    w_cand     = '0;
    w_canGrant = w_slotAccept & (~w_full | w_pop);
    if (w_canGrant) begin
      for (int k = NumPorts - 1; k >= 0; k--) begin
        w_cand = nextPort(r_rrPtr, k);
        for (int j = 0; j < NumPorts; j++) begin
          if ((w_cand == PortIdWidth'(j)) && i_reqAddrValid[j]) begin
            w_grantVec    = '0;
            w_grantVec[j] = 1'b1;
            w_grantId     = w_cand;
          end
        end
      end
    end
  end

  assign w_push        = |w_grantVec;
  assign o_reqAddrStop = ~w_grantVec;

  always_comb begin
    w_grantAddr = '0;
    for (int j = 0; j < NumPorts; j++) begin
      if (w_grantVec[j]) begin
        w_grantAddr = i_reqAddr[32*j +: 32];
      end
    end
  end

  // Slot and round-robin pointer. A new grant overwrites the slot in the
  // same cycle the previous address is consumed, giving full throughput.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_slotValid <= 1'b0;
      r_slotAddr  <= '0;
      r_rrPtr     <= '0;
    end else if (w_push) begin
      r_slotValid <= 1'b1;
      r_slotAddr  <= w_grantAddr;
      r_rrPtr     <= nextPort(w_grantId, 1);
    end else if (w_slotConsumed) begin
      r_slotValid <= 1'b0;
    end
  end

  // Tag storage carries no reset: entries are only read between a push and
  // its pop, and the empty flag gates every use of the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tagMem[r_wrPtr] <= w_grantId;
    end
  end

  // FIFO pointers wrap naturally because TagDepth is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PtrOne;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PtrOne;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CountOne;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CountOne;
      end
    end
  end

  assign o_paramAddrValid = r_slotValid;
  assign o_paramAddr      = r_slotAddr;
  assign o_outstanding    = r_count;

endmodule

// File: tb/tb_sda_kernel_param_arbiter.sv
// tb_sda_kernel_param_arbiter
//
// Purpose:
//   Directed bench for sda_kernel_param_arbiter. A queue-based reference model
//   (pending requests per port, list of in-flight requester ids, one address
//   slot) predicts every DUT output each cycle; directed scenarios add
//   hand-computed literal checks on grant order, issued addresses and data
//   routing.

module tb_sda_kernel_param_arbiter;

  localparam int NumPorts    = 4;
  localparam int PortIdWidth = 2;
  localparam int TagDepth    = 8;
  localparam int TagPtrWidth = 3;

  logic                    clk = 1'b0;
  logic                    srst;
  logic [NumPorts-1:0]     i_reqAddrValid;
  logic [32*NumPorts-1:0]  i_reqAddr;
  logic [NumPorts-1:0]     o_reqAddrStop;
  logic [NumPorts-1:0]     o_reqDataValid;
  logic [32*NumPorts-1:0]  o_reqData;
  logic [NumPorts-1:0]     i_reqDataStop;
  logic                    o_paramAddrValid;
  logic [31:0]             o_paramAddr;
  logic                    i_paramAddrStop;
  logic                    i_paramDataValid;
  logic [31:0]             i_paramData;
  logic                    o_paramDataStop;
  logic [TagPtrWidth:0]    o_outstanding;

  always #5 clk = ~clk;

  sda_kernel_param_arbiter #(
    .NumPorts(NumPorts), .PortIdWidth(PortIdWidth),
    .TagDepth(TagDepth), .TagPtrWidth(TagPtrWidth)
  ) dut (
    .clk(clk), .srst(srst),
    .i_reqAddrValid(i_reqAddrValid), .i_reqAddr(i_reqAddr),
    .o_reqAddrStop(o_reqAddrStop),
    .o_reqDataValid(o_reqDataValid), .o_reqData(o_reqData),
    .i_reqDataStop(i_reqDataStop),
    .o_paramAddrValid(o_paramAddrValid), .o_paramAddr(o_paramAddr),
    .i_paramAddrStop(i_paramAddrStop),
    .i_paramDataValid(i_paramDataValid), .i_paramData(i_paramData),
    .o_paramDataStop(o_paramDataStop),
    .o_outstanding(o_outstanding)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus controls, applied to the DUT just after each rising edge
  logic                srstCtl = 1'b1;
  logic                addrStopCtl = 1'b0;
  logic                ramEnable = 1'b0;
  logic [NumPorts-1:0] dataStopCtl = '0;
  logic [31:0]         reqQ [NumPorts][$];
  logic [31:0]         ramQ [$];
  logic [NumPorts-1:0] sawAddrXfer = '0;
  bit                  sawDataXfer = 1'b0;

  // Reference model state
  bit          modelReady = 1'b0;
  bit          mSlotValid;
  logic [31:0] mSlotAddr;
  int          mRr;
  int          mTags [$];

  // Observation logs
  typedef struct { int port; logic [31:0] data; } rx_t;
  int          grantLog [$];
  logic [31:0] issueLog [$];
  rx_t         rxLog [$];
  int          maxOut;
  int          cyc = 0;
  int          lastGrantCycle = -1;
  int          lastPopCycle = -2;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int pickWinner(input logic [NumPorts-1:0] v, input int rr);
    for (int k = 0; k < NumPorts; k++) begin
      if (v[(rr + k) % NumPorts]) return (rr + k) % NumPorts;
    end
    return -1;
  endfunction

  // What the arbiter must do this cycle given the model state and live inputs
  function automatic void modelExpect(output logic [NumPorts-1:0] expStop,
                                      output bit expPds, output bit popNow,
                                      output int win);
    int  n;
    bit  accept;
    n       = mTags.size();
    expPds  = (n == 0) ? 1'b1 : i_reqDataStop[mTags[0]];
    popNow  = i_paramDataValid && !expPds;
    accept  = !mSlotValid || !i_paramAddrStop;
    win     = (accept && (n < TagDepth || popNow)) ? pickWinner(i_reqAddrValid, mRr) : -1;
    expStop = '1;
    if (win >= 0) expStop[win] = 1'b0;
  endfunction

  logic [NumPorts-1:0] uStop;
  bit                  uPds, uPop;
  int                  uWin;

  always @(posedge clk) begin
    if (srst) begin
      mSlotValid = 1'b0;
      mSlotAddr  = '0;
      mRr        = 0;
      mTags.delete();
      modelReady = 1'b1;
    end else if (modelReady) begin
      modelExpect(uStop, uPds, uPop, uWin);
      if (uPop) void'(mTags.pop_front());
      if (uWin >= 0) begin
        mTags.push_back(uWin);
        mSlotValid = 1'b1;
        mSlotAddr  = i_reqAddr[32*uWin +: 32];
        mRr        = (uWin + 1) % NumPorts;
      end else if (mSlotValid && !i_paramAddrStop) begin
        mSlotValid = 1'b0;
      end
    end
  end

  logic [NumPorts-1:0]    eStop, eDv;
  logic [32*NumPorts-1:0] eData;
  bit                     ePds, ePop;
  int                     eWin;

  // Per-cycle compare and transfer logging, away from the active edge
  always @(negedge clk) begin
    cyc++;
    sawAddrXfer = '0;
    sawDataXfer = 1'b0;
    if (modelReady) begin
      modelExpect(eStop, ePds, ePop, eWin);
      eDv   = '0;
      eData = '0;
      if (mTags.size() > 0) begin
        eDv[mTags[0]]             = i_paramDataValid;
        eData[32*mTags[0] +: 32]  = i_paramData;
      end
      checkOutput("reqAddrStop", o_reqAddrStop, eStop);
      checkOutput("paramAddrValid", o_paramAddrValid, mSlotValid);
      checkOutput("paramAddr", o_paramAddr, mSlotValid ? mSlotAddr : o_paramAddr & 32'h0 | mSlotAddr);
      checkOutput("outstanding", o_outstanding, mTags.size());
      checkOutput("paramDataStop", o_paramDataStop, ePds);
      checkOutput("reqDataValid", o_reqDataValid, eDv);
      checkOutput("reqData", o_reqData, eData);
    end
    if (!srst) begin
      for (int j = 0; j < NumPorts; j++) begin
        if (i_reqAddrValid[j] && !o_reqAddrStop[j]) begin
          sawAddrXfer[j] = 1'b1;
          grantLog.push_back(j);
          lastGrantCycle = cyc;
        end
        if (o_reqDataValid[j] && !i_reqDataStop[j])
          rxLog.push_back('{port: j, data: o_reqData[32*j +: 32]});
      end
      if (o_paramAddrValid && !i_paramAddrStop) issueLog.push_back(o_paramAddr);
      if (i_paramDataValid && !o_paramDataStop) begin
        sawDataXfer  = 1'b1;
        lastPopCycle = cyc;
      end
      if (int'(o_outstanding) > maxOut) maxOut = int'(o_outstanding);
    end
  end

  // Requester and RAM drivers: hold valid/data until a transfer is seen
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < NumPorts; j++) begin
      if (sawAddrXfer[j] && reqQ[j].size() > 0) void'(reqQ[j].pop_front());
      i_reqAddrValid[j]     = (reqQ[j].size() > 0);
      i_reqAddr[32*j +: 32] = (reqQ[j].size() > 0) ? reqQ[j][0] : 32'h0;
    end
    if (sawDataXfer && ramQ.size() > 0) void'(ramQ.pop_front());
    i_paramDataValid = ramEnable && (ramQ.size() > 0);
    i_paramData      = (ramQ.size() > 0) ? ramQ[0] : 32'h0;
    i_paramAddrStop  = addrStopCtl;
    i_reqDataStop    = dataStopCtl;
    srst             = srstCtl;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clearLogs();
    grantLog.delete();
    issueLog.delete();
    rxLog.delete();
    maxOut         = 0;
    lastGrantCycle = -1;
    lastPopCycle   = -2;
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] addr);
    reqQ[port].push_back(addr);
  endtask

  task automatic resetDut();
    srstCtl = 1'b1;
    for (int j = 0; j < NumPorts; j++) reqQ[j].delete();
    ramQ.delete();
    addrStopCtl = 1'b0;
    dataStopCtl = '0;
    ramEnable   = 1'b0;
    tick(3);
    srstCtl = 1'b0;
    tick(2);
    clearLogs();
  endtask

  function automatic bit allIdle();
    bit idle;
    idle = (o_outstanding == '0) && !o_paramAddrValid;
    for (int j = 0; j < NumPorts; j++) if (reqQ[j].size() > 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic waitIdle(input string name, input int budget);
    int n;
    bit idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      tick(1);
      n++;
      idle = allIdle();
    end
    checkOutput({name, ".idle"}, idle, 1'b1);
  endtask

  task automatic checkGrant(input string name, input int k, input int port);
    if (k < grantLog.size()) checkOutput(name, grantLog[k], port);
    else checkOutput({name, ".missing"}, grantLog.size(), k + 1);
  endtask

  task automatic checkIssue(input string name, input int k, input logic [31:0] addr);
    if (k < issueLog.size()) checkOutput(name, issueLog[k], addr);
    else checkOutput({name, ".missing"}, issueLog.size(), k + 1);
  endtask

  task automatic checkRx(input string name, input int k, input int port,
                         input logic [31:0] data);
    if (k < rxLog.size()) begin
      checkOutput({name, ".port"}, rxLog[k].port, port);
      checkOutput({name, ".data"}, rxLog[k].data, data);
    end else begin
      checkOutput({name, ".missing"}, rxLog.size(), k + 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    srst             = 1'b1;
    i_reqAddrValid   = '0;
    i_reqAddr        = '0;
    i_reqDataStop    = '0;
    i_paramAddrStop  = 1'b0;
    i_paramDataValid = 1'b0;
    i_paramData      = '0;

    // Reset state
    tick(2);
    checkOutput("rst.paramAddrValid", o_paramAddrValid, 1'b0);
    checkOutput("rst.paramAddr", o_paramAddr, 32'h0);
    checkOutput("rst.outstanding", o_outstanding, 0);
    checkOutput("rst.reqDataValid", o_reqDataValid, 4'h0);
    checkOutput("rst.paramDataStop", o_paramDataStop, 1'b1);
    checkOutput("rst.reqAddrStop", o_reqAddrStop, 4'hF);

    // 1: single requester, three back-to-back reads
    resetDut();
    applyStimulus(0, 32'h40);
    applyStimulus(0, 32'h44);
    applyStimulus(0, 32'h48);
    ramQ = '{32'hA, 32'hB, 32'hC};
    tick(6);
    checkOutput("t1.outstandingPeak", o_outstanding, 3);
    ramEnable = 1'b1;
    waitIdle("t1", 50);
    checkIssue("t1.issue0", 0, 32'h40);
    checkIssue("t1.issue1", 1, 32'h44);
    checkIssue("t1.issue2", 2, 32'h48);
    checkRx("t1.rx0", 0, 0, 32'hA);
    checkRx("t1.rx1", 1, 0, 32'hB);
    checkRx("t1.rx2", 2, 0, 32'hC);
    checkOutput("t1.maxOut", maxOut, 3);
    checkOutput("t1.outstandingEnd", o_outstanding, 0);

    // 2: fairness between ports 0 and 2
    resetDut();
    applyStimulus(0, 32'h100);
    applyStimulus(0, 32'h104);
    applyStimulus(2, 32'h200);
    applyStimulus(2, 32'h204);
    ramQ = '{32'h10, 32'h11, 32'h12, 32'h13};
    ramEnable = 1'b1;
    waitIdle("t2", 60);
    checkGrant("t2.grant0", 0, 0);
    checkGrant("t2.grant1", 1, 2);
    checkGrant("t2.grant2", 2, 0);
    checkGrant("t2.grant3", 3, 2);
    checkIssue("t2.issue1", 1, 32'h200);
    checkRx("t2.rx0", 0, 0, 32'h10);
    checkRx("t2.rx1", 1, 2, 32'h11);
    checkRx("t2.rx2", 2, 0, 32'h12);
    checkRx("t2.rx3", 3, 2, 32'h13);

    // 3: address backpressure holds the slot and blocks further grants
    resetDut();
    addrStopCtl = 1'b1;
    applyStimulus(1, 32'h300);
    applyStimulus(3, 32'h304);
    tick(7);
    checkOutput("t3.paramAddrValid", o_paramAddrValid, 1'b1);
    checkOutput("t3.paramAddr", o_paramAddr, 32'h300);
    checkOutput("t3.reqAddrStop", o_reqAddrStop, 4'hF);
    checkOutput("t3.outstanding", o_outstanding, 1);
    checkOutput("t3.grants", grantLog.size(), 1);
    checkOutput("t3.issued", issueLog.size(), 0);
    addrStopCtl = 1'b0;
    ramQ = '{32'h20, 32'h21};
    ramEnable = 1'b1;
    waitIdle("t3", 50);
    checkGrant("t3.grant1", 1, 3);
    checkRx("t3.rx0", 0, 1, 32'h20);
    checkRx("t3.rx1", 1, 3, 32'h21);

    // 4: tag FIFO full, then push and pop in the same cycle
    resetDut();
    for (int k = 0; k < 9; k++) applyStimulus(0, 32'h400 + 32'(4 * k));
    tick(14);
    checkOutput("t4.outstandingFull", o_outstanding, 8);
    checkOutput("t4.reqAddrStopFull", o_reqAddrStop, 4'hF);
    checkOutput("t4.grantsFull", grantLog.size(), 8);
    ramQ = '{32'h30};
    ramEnable = 1'b1;
    tick(2);
    checkOutput("t4.outstandingAfter", o_outstanding, 8);
    checkOutput("t4.grantsAfter", grantLog.size(), 9);
    checkOutput("t4.sameCycle", lastGrantCycle, lastPopCycle);
    checkRx("t4.rx0", 0, 0, 32'h30);
    for (int k = 1; k <= 8; k++) ramQ.push_back(32'h30 + 32'(k));
    waitIdle("t4", 80);
    checkRx("t4.rxLast", 8, 0, 32'h38);

    // 5: stalled head blocks the younger request of another port
    resetDut();
    applyStimulus(1, 32'h500);
    tick(3);
    applyStimulus(0, 32'h504);
    tick(4);
    dataStopCtl = 4'b0010;
    ramQ = '{32'h50, 32'h51};
    ramEnable = 1'b1;
    tick(4);
    checkOutput("t5.paramDataStop", o_paramDataStop, 1'b1);
    checkOutput("t5.noData", rxLog.size(), 0);
    checkOutput("t5.outstanding", o_outstanding, 2);
    dataStopCtl = '0;
    waitIdle("t5", 50);
    checkGrant("t5.grant0", 0, 1);
    checkRx("t5.rx0", 0, 1, 32'h50);
    checkRx("t5.rx1", 1, 0, 32'h51);

    // 6: reset with reads outstanding and the slot full
    resetDut();
    applyStimulus(0, 32'h600);
    applyStimulus(1, 32'h604);
    tick(4);
    addrStopCtl = 1'b1;
    applyStimulus(2, 32'h608);
    tick(3);
    checkOutput("t6.preOutstanding", o_outstanding, 3);
    checkOutput("t6.preSlot", o_paramAddrValid, 1'b1);
    checkOutput("t6.preAddr", o_paramAddr, 32'h608);
    srstCtl = 1'b1;
    for (int j = 0; j < NumPorts; j++) reqQ[j].delete();
    tick(2);
    checkOutput("t6.outstanding", o_outstanding, 0);
    checkOutput("t6.paramAddrValid", o_paramAddrValid, 1'b0);
    checkOutput("t6.paramDataStop", o_paramDataStop, 1'b1);
    srstCtl     = 1'b0;
    addrStopCtl = 1'b0;
    tick(1);
    clearLogs();
    for (int j = 0; j < NumPorts; j++) applyStimulus(j, 32'h700 + 32'(4 * j));
    tick(3);
    checkGrant("t6.firstGrant", 0, 0);
    ramQ = '{32'h60, 32'h61, 32'h62, 32'h63};
    ramEnable = 1'b1;
    waitIdle("t6", 60);
    checkRx("t6.rx0", 0, 0, 32'h60);
    checkRx("t6.rx3", 3, 3, 32'h63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
